// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes and bit-period helper.
// Used by both the transmitter and the receiver.
package uart_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  function automatic int bit_cycles(
    input int clk_freq,
    input int baudrate
  );
    return clk_freq / baudrate;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// Resets to 1 so an idle-high line does not look like an edge.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, LSB first,
// sticky byte-ready / frame-error / overrun flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int Nbit     = 8,
  parameter int baudrate = 5,
  parameter int clk_freq = 50
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            SerialDataIn,
  input  logic            clr_rx_flag,
  output logic [Nbit-1:0] DataRx,
  output logic            endRx_flag,
  output logic            frame_error,
  output logic            overrun
);

  localparam int BC = bit_cycles(clk_freq, baudrate);
  localparam int CW = $clog2(BC);
  localparam int BW = $clog2(Nbit + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(BC - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(BC / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(Nbit - 1);

  logic            rx_s;
  logic            rx_q;
  logic            fall;
  logic            tick;
  logic [2:0]      state;
  logic [CW-1:0]   cnt;
  logic [BW-1:0]   bit_idx;
  logic [Nbit-1:0] shreg;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (SerialDataIn),
    .q     (rx_s)
  );

  assign fall = rx_q & ~rx_s;
  assign tick = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rx_q <= 1'b1;
    else        rx_q <= rx_s;
  end

  // Counter restarts at mid-start so later ticks land mid-bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (state == IDLE || state == BREAK) begin
      cnt <= '0;
    end else if (state == START && cnt == CNT_HALF) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      bit_idx     <= '0;
      shreg       <= '0;
      DataRx      <= '0;
      endRx_flag  <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (clr_rx_flag) begin
        endRx_flag  <= 1'b0;
        frame_error <= 1'b0;
        overrun     <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (fall) state <= START;
        end
        START: begin
          if (cnt == CNT_HALF) begin
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end
        end
        DATA: begin
          if (tick) begin
            shreg <= {rx_s, shreg[Nbit-1:1]};
            if (bit_idx == BIT_LAST) begin
              bit_idx <= '0;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + BW'(1);
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (rx_s) begin
              DataRx     <= shreg;
              endRx_flag <= 1'b1;
              if (endRx_flag) overrun <= 1'b1;
              state      <= IDLE;
            end else begin
              frame_error <= 1'b1;
              state       <= BREAK;
            end
          end
        end
        BREAK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised self-checking bench for uart_rx against a
// frame-level model of the receiver's outputs.
module tb_uart_rx;

  localparam int BC = 50 / 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       SerialDataIn = 1'b1;
  logic       clr_rx_flag = 1'b0;
  logic [7:0] DataRx;
  logic       endRx_flag;
  logic       frame_error;
  logic       overrun;

  uart_rx #(
    .Nbit     (8),
    .baudrate (5),
    .clk_freq (50)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .SerialDataIn (SerialDataIn),
    .clr_rx_flag  (clr_rx_flag),
    .DataRx       (DataRx),
    .endRx_flag   (endRx_flag),
    .frame_error  (frame_error),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] m_data = 8'h00;
  bit m_end = 0;
  bit m_fe  = 0;
  bit m_ov  = 0;
  bit quiet = 0;

  int n_chk = 0;
  int n_pass = 0;
  int n_prn = 0;
  int t0 = 0;
  int t_rise = -1;
  bit prev_end = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      if (n_prn < 40)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                 nm, act, exp, cyc);
      n_prn++;
    end
  endtask

  always @(negedge clk) begin
    if (endRx_flag === 1'b1 && !prev_end) t_rise = cyc;
    prev_end = (endRx_flag === 1'b1);
  end

  always @(negedge clk) begin
    if (quiet) begin
      chk("DataRx", {24'd0, DataRx}, {24'd0, m_data});
      chk("endRx_flag", {31'd0, endRx_flag}, {31'd0, m_end});
      chk("frame_error", {31'd0, frame_error}, {31'd0, m_fe});
      chk("overrun", {31'd0, overrun}, {31'd0, m_ov});
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(input logic [7:0] b, input bit stop_bit);
    t0 = cyc + 1;
    t_rise = -1;
    SerialDataIn = 1'b0;
    wait_cyc(BC);
    for (int i = 0; i < 8; i++) begin
      SerialDataIn = b[i];
      wait_cyc(BC);
    end
    SerialDataIn = stop_bit;
    wait_cyc(BC);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                            input int low_tail);
    bit rise_due;
    int lat;
    quiet = 0;
    rise_due = stop_ok && !m_end;
    drive_frame(b, stop_ok);
    if (stop_ok) begin
      if (m_end) m_ov = 1;
      m_end  = 1;
      m_data = b;
    end else begin
      m_fe = 1;
    end
    quiet = 1;
    if (rise_due) begin
      lat = t_rise - t0;
      n_chk++;
      if (t_rise >= 0 && lat >= 92 && lat <= 99) begin
        n_pass++;
      end else begin
        $display("FAIL latency: got %0d clocks expected 92..99", lat);
        n_prn++;
      end
    end
    if (low_tail > 0) wait_cyc(low_tail);
    SerialDataIn = 1'b1;
    wait_cyc(3);
  endtask

  task automatic pulse_clr();
    quiet = 0;
    @(negedge clk);
    clr_rx_flag = 1'b1;
    @(negedge clk);
    clr_rx_flag = 1'b0;
    m_end = 0;
    m_fe  = 0;
    m_ov  = 0;
    wait_cyc(1);
    quiet = 1;
  endtask

  task automatic glitch(input int n);
    SerialDataIn = 1'b0;
    wait_cyc(n);
    SerialDataIn = 1'b1;
    wait_cyc(2 * BC);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    #1 reset = 1'b0;
    wait_cyc(3);
    chk("reset_DataRx", {24'd0, DataRx}, 32'h0);
    chk("reset_endRx", {31'd0, endRx_flag}, 32'h0);
    chk("reset_frame_error", {31'd0, frame_error}, 32'h0);
    chk("reset_overrun", {31'd0, overrun}, 32'h0);
    reset = 1'b1;
    quiet = 1;
    wait_cyc(5);

    send_frame(8'b0101_0101, 1, 0);
    chk("t1_DataRx", {24'd0, DataRx}, 32'h55);
    chk("t1_endRx", {31'd0, endRx_flag}, 32'h1);
    chk("t1_frame_error", {31'd0, frame_error}, 32'h0);
    wait_cyc(BC);

    glitch(3);
    chk("t2_DataRx", {24'd0, DataRx}, 32'h55);
    chk("t2_endRx", {31'd0, endRx_flag}, 32'h1);

    pulse_clr();
    send_frame(8'hA3, 0, 30);
    chk("t3_frame_error", {31'd0, frame_error}, 32'h1);
    chk("t3_endRx", {31'd0, endRx_flag}, 32'h0);
    chk("t3_DataRx", {24'd0, DataRx}, 32'h55);
    wait_cyc(2 * BC);

    pulse_clr();
    send_frame(8'h12, 1, 0);
    wait_cyc(BC);
    send_frame(8'h34, 1, 0);
    chk("t4_DataRx", {24'd0, DataRx}, 32'h34);
    chk("t4_endRx", {31'd0, endRx_flag}, 32'h1);
    chk("t4_overrun", {31'd0, overrun}, 32'h1);
    pulse_clr();
    chk("t4_clr_endRx", {31'd0, endRx_flag}, 32'h0);
    chk("t4_clr_overrun", {31'd0, overrun}, 32'h0);
    chk("t4_clr_DataRx", {24'd0, DataRx}, 32'h34);
    wait_cyc(BC);

    // Hold clear high right up to the cycle the byte lands.
    seen = 0;
    fork
      send_frame(8'hC6, 1, 0);
      begin
        @(negedge clk);
        for (int i = 0; i < 200 && cyc < t0 + 88; i++) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
          if (endRx_flag !== 1'b1) begin
            clr_rx_flag = 1'b1;
          end else begin
            clr_rx_flag = 1'b0;
            seen = 1;
            break;
          end
          @(negedge clk);
        end
        clr_rx_flag = 1'b0;
      end
    join
    chk("t5_race_seen", {31'd0, seen}, 32'h1);
    chk("t5_endRx", {31'd0, endRx_flag}, 32'h1);
    wait_cyc(BC);

    pulse_clr();
    quiet = 0;
    fork
      drive_frame(8'hFF, 1);
      begin
        wait_cyc(40);
        reset  = 1'b0;
        m_data = 8'h00;
        m_end  = 0;
        m_fe   = 0;
        m_ov   = 0;
        quiet  = 1;
        wait_cyc(3);
        chk("t6_rst_DataRx", {24'd0, DataRx}, 32'h0);
        chk("t6_rst_endRx", {31'd0, endRx_flag}, 32'h0);
        reset = 1'b1;
      end
    join
    SerialDataIn = 1'b1;
    wait_cyc(2 * BC);
    send_frame(8'h0F, 1, 0);
    chk("t6_DataRx", {24'd0, DataRx}, 32'h0F);
    chk("t6_endRx", {31'd0, endRx_flag}, 32'h1);
    wait_cyc(BC);

    for (int k = 0; k < 40; k++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) glitch($urandom_range(1, 3));
      else if (r == 1) pulse_clr();
      else send_frame(8'($urandom), $urandom_range(0, 5) != 0, 0);
      SerialDataIn = 1'b1;
      wait_cyc($urandom_range(BC, 3 * BC));
    end

    quiet = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
